symbol_phase_accum: RTL and testbench

SYMBOL_PHASE_ACCUM -- requirements
Module: symbol_phase_accum

---
 rtl/symbol_phase_accum.sv | 107 ++++++++++
 tb/tb_symbol_phase_accum.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/symbol_phase_accum.sv
// Per-symbol phase-change accumulator: sums wrapped phase deltas across a symbol and emits the
// saturated 8-bit total one clock after the next symbol marker, flagging sync loss on overlong symbols.
module symbol_phase_accum #(
    parameter int unsigned MAX_SPS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sampleEn,
    input  logic       symEn,
    input  logic [7:0] phaseIn,
    output logic [7:0] dout,
    output logic       enOut,
    output logic       satOut,
    output logic       syncErr
);

    localparam logic [3:0] MaxCnt = 4'(MAX_SPS);

    typedef enum logic [0:0] {StSync, StRun} state_e;

    state_e            state_q;
    logic [7:0]        last_q;
    logic signed [11:0] acc_q;
    logic [3:0]        cnt_q;
    logic [7:0]        dout_q;
    logic              en_q;
    logic              sat_q;
    logic              err_q;

    logic [7:0]         diff;
    logic signed [11:0] delta;
    logic signed [11:0] total;
    logic [7:0]         sat_val;
    logic               sat_hit;

    // Modular subtraction then sign extension handles wrap across 0x00/0xFF.
    always_comb begin
        diff    = phaseIn - last_q;
        delta   = {{4{diff[7]}}, diff};
        total   = acc_q + delta;
        sat_val = total[7:0];
        sat_hit = 1'b0;
        if (total > 12'sd127) begin
            sat_val = 8'h7F;
            sat_hit = 1'b1;
        end else if (total < -12'sd128) begin
            sat_val = 8'h80;
            sat_hit = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StSync;
            last_q  <= 8'h00;
            acc_q   <= '0;
            cnt_q   <= '0;
            dout_q  <= 8'h00;
            en_q    <= 1'b0;
            sat_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            en_q  <= 1'b0;
            sat_q <= 1'b0;
            err_q <= 1'b0;
            if (sampleEn) begin
                unique case (state_q)
                    StSync: begin
                        if (symEn) begin
                            last_q  <= phaseIn;
                            acc_q   <= '0;
                            cnt_q   <= 4'd1;
                            state_q <= StRun;
                        end
                    end
                    StRun: begin
                        if (symEn) begin
                            last_q <= phaseIn;
                            acc_q  <= '0;
                            cnt_q  <= 4'd1;
                            dout_q <= sat_val;
                            en_q   <= 1'b1;
                            sat_q  <= sat_hit;
                        end else if (cnt_q >= MaxCnt) begin
                            // Symbol overran: drop it and wait for a fresh marker.
                            acc_q   <= '0;
                            cnt_q   <= '0;
                            err_q   <= 1'b1;
                            state_q <= StSync;
                        end else begin
                            last_q <= phaseIn;
                            acc_q  <= total;
                            cnt_q  <= cnt_q + 4'd1;
                        end
                    end
                    default: state_q <= StSync;
                endcase
            end
        end
    end

    assign dout    = dout_q;
    assign enOut   = en_q;
    assign satOut  = sat_q;
    assign syncErr = err_q;

endmodule

// File: tb/tb_symbol_phase_accum.sv
// Bench for symbol_phase_accum: directed cases plus random traffic against a queue-based symbol model.
module tb_symbol_phase_accum;

    localparam int MaxSps = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       sampleEn;
    logic       symEn;
    logic [7:0] phaseIn;
    logic [7:0] dout;
    logic       enOut;
    logic       satOut;
    logic       syncErr;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: phases of the open symbol, oldest first; empty means not synchronised.
    int         sym_q[$];
    bit         m_sync;
    logic [7:0] m_dout;

    symbol_phase_accum #(.MAX_SPS(MaxSps)) dut (
        .clk      (clk),
        .reset    (reset),
        .sampleEn (sampleEn),
        .symEn    (symEn),
        .phaseIn  (phaseIn),
        .dout     (dout),
        .enOut    (enOut),
        .satOut   (satOut),
        .syncErr  (syncErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int wrap_delta(input int d);
        int m;
        m = ((d % 256) + 256) % 256;
        return (m > 127) ? m - 256 : m;
    endfunction

    task automatic model_reset();
        sym_q.delete();
        m_sync = 1'b0;
        m_dout = 8'h00;
    endtask

    task automatic step(input bit se, input bit sy, input logic [7:0] ph, input string tag);
        bit e_en;
        bit e_sat;
        bit e_err;
        int total;
        e_en  = 1'b0;
        e_sat = 1'b0;
        e_err = 1'b0;
        sampleEn = se;
        symEn    = sy;
        phaseIn  = ph;
        if (se) begin
            if (!m_sync) begin
                if (sy) begin
                    m_sync = 1'b1;
                    sym_q.delete();
                    sym_q.push_back(int'(ph));
                end
            end else if (sy) begin
                sym_q.push_back(int'(ph));
                total = 0;
                for (int i = 1; i < sym_q.size(); i++)
                    total += wrap_delta(sym_q[i] - sym_q[i-1]);
                e_en  = 1'b1;
                e_sat = (total > 127) || (total < -128);
                if (total > 127)       m_dout = 8'h7F;
                else if (total < -128) m_dout = 8'h80;
                else                   m_dout = 8'(total);
                sym_q.delete();
                sym_q.push_back(int'(ph));
            end else if (sym_q.size() >= MaxSps) begin
                e_err  = 1'b1;
                m_sync = 1'b0;
                sym_q.delete();
            end else begin
                sym_q.push_back(int'(ph));
            end
        end
        @(posedge clk);
        #1;
        chk({tag, "_en"},  12'(enOut),   12'(e_en));
        chk({tag, "_sat"}, 12'(satOut),  12'(e_sat));
        chk({tag, "_err"}, 12'(syncErr), 12'(e_err));
        chk({tag, "_dout"}, 12'(dout),   12'(m_dout));
        sampleEn = 1'b0;
        symEn    = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        sampleEn = 1'b0;
        symEn    = 1'b0;
        phaseIn  = 8'h00;
        model_reset();
        #1;
        chk("rst_dout", 12'(dout), 12'h000);
        chk("rst_en",   12'(enOut), 12'h000);
        chk("rst_sat",  12'(satOut), 12'h000);
        chk("rst_err",  12'(syncErr), 12'h000);
        chk("rst_acc",  dut.acc_q, 12'h000);
        repeat (2) @(posedge clk);
        #4 reset = 1'b0;

        // Unsynchronised samples are ignored.
        step(1, 0, 8'h10, "nosync0");
        step(1, 0, 8'h20, "nosync1");
        chk("nosync_en", 12'(enOut), 12'h000);

        // Three +16 steps give +48.
        step(1, 1, 8'h10, "s28_sync");
        step(1, 0, 8'h20, "s28_a");
        step(1, 0, 8'h30, "s28_b");
        step(1, 1, 8'h40, "s28_close");
        chk("s28_dout", 12'(dout), 12'h030);
        chk("s28_sat",  12'(satOut), 12'h000);
        step(0, 0, 8'hAA, "s28_hold");
        chk("s28_hold_dout", 12'(dout), 12'h030);

        // Wrap 0xF0 -> 0x10 is +32; this also restarts from a one-sample symbol.
        step(1, 1, 8'hF0, "wrap_pre");
        step(1, 1, 8'h10, "wrap_close");
        chk("wrap_dout", 12'(dout), 12'h020);

        // +400 saturates high.
        step(1, 1, 8'h00, "sath_sync");
        step(1, 0, 8'h64, "sath_a");
        step(1, 0, 8'hC8, "sath_b");
        step(1, 0, 8'h2C, "sath_c");
        step(1, 1, 8'h90, "sath_close");
        chk("sath_dout", 12'(dout), 12'h07F);
        chk("sath_sat",  12'(satOut), 12'h001);

        // -400 saturates low.
        step(1, 1, 8'h00, "satl_sync");
        step(1, 0, 8'h9C, "satl_a");
        step(1, 0, 8'h38, "satl_b");
        step(1, 0, 8'hD4, "satl_c");
        step(1, 1, 8'h70, "satl_close");
        chk("satl_dout", 12'(dout), 12'h080);
        chk("satl_sat",  12'(satOut), 12'h001);

        // Overlong symbol: error after the 8th plain sample, then ignored until a marker.
        step(1, 1, 8'h05, "ovf_sync");
        for (int i = 0; i < MaxSps - 1; i++) step(1, 0, 8'(8'h10 * i), "ovf_s");
        step(1, 0, 8'h77, "ovf_last");
        chk("ovf_err", 12'(syncErr), 12'h001);
        chk("ovf_en",  12'(enOut), 12'h000);
        step(1, 0, 8'h33, "ovf_ign0");
        chk("ovf_err_once", 12'(syncErr), 12'h000);
        step(1, 0, 8'h44, "ovf_ign1");
        step(1, 1, 8'h50, "ovf_resync");
        chk("ovf_resync_en", 12'(enOut), 12'h000);
        step(1, 1, 8'h58, "ovf_close");
        chk("ovf_close_dout", 12'(dout), 12'h008);

        // Asynchronous reset mid-symbol discards the partial sum.
        step(1, 0, 8'h70, "mid_a");
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_dout", 12'(dout), 12'h000);
        chk("mid_rst_en",   12'(enOut), 12'h000);
        chk("mid_rst_acc",  dut.acc_q, 12'h000);
        #1 reset = 1'b0;
        model_reset();
        step(1, 1, 8'h20, "post_rst_sync");
        chk("post_rst_en", 12'(enOut), 12'h000);
        step(1, 0, 8'h28, "post_rst_a");
        step(1, 1, 8'h30, "post_rst_close");
        chk("post_rst_dout", 12'(dout), 12'h010);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 4) == 0),
                 8'($urandom_range(0, 255)), "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
